// File: rtl/vend_dispenser_if.sv
// Handshake bundle between the upstream vending FSM (master) and the
// dispenser actuator stage (slave).
interface vend_dispenser_if;
    logic       soda_i;
    logic [2:0] change_i;
    logic       coin_seen_i;
    logic       soda_sol_o;
    logic       coin_eject_o;
    logic [2:0] owed_o;
    logic       busy_o;
    logic       pending_o;
    logic       drop_o;
    logic       fault_o;

    modport master (
        output soda_i, change_i, coin_seen_i,
        input  soda_sol_o, coin_eject_o, owed_o, busy_o, pending_o, drop_o, fault_o
    );

    modport slave (
        input  soda_i, change_i, coin_seen_i,
        output soda_sol_o, coin_eject_o, owed_o, busy_o, pending_o, drop_o, fault_o
    );
endinterface

// File: rtl/vend_dispenser.sv
// Vending actuator stage: times the soda solenoid, ejects owed nickels one at a
// time against the exit sensor, buffers one request and latches a sticky fault.
module vend_dispenser #(
    parameter int SODA_CYC    = 8,
    parameter int EJECT_CYC   = 4,
    parameter int GAP_CYC     = 2,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    vend_dispenser_if.slave  bus
);

    localparam int MAX_A   = (SODA_CYC > EJECT_CYC) ? SODA_CYC : EJECT_CYC;
    localparam int MAX_B   = (GAP_CYC > TIMEOUT_CYC) ? GAP_CYC : TIMEOUT_CYC;
    localparam int MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SODA,
        S_EJECT,
        S_WAIT,
        S_GAP,
        S_FAULT
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [2:0]         r_owed;
    logic               r_pend_vld;
    logic [2:0]         r_pend_chg;
    logic               r_drop;

    logic               w_start;
    logic [2:0]         w_start_chg;
    logic               w_to_slot;

    // The buffered request always outranks a fresh strobe when idle.
    assign w_start     = (r_state == S_IDLE) && (r_pend_vld || bus.soda_i);
    assign w_start_chg = r_pend_vld ? r_pend_chg : bus.change_i;
    assign w_to_slot   = bus.soda_i && ((r_state != S_IDLE) || r_pend_vld);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_owed     <= '0;
            r_pend_vld <= 1'b0;
            r_pend_chg <= '0;
            r_drop     <= 1'b0;
        end else begin
            r_drop <= 1'b0;

            // An idle slot that is being consumed this cycle may be refilled at once.
            if (w_to_slot) begin
                if (!r_pend_vld || r_state == S_IDLE) begin
                    r_pend_vld <= 1'b1;
                    r_pend_chg <= bus.change_i;
                end else begin
                    r_drop <= 1'b1;
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_owed  <= w_start_chg;
                        r_cnt   <= '0;
                        r_state <= (w_start_chg > 3'd4) ? S_FAULT : S_SODA;
                        if (r_pend_vld && !bus.soda_i) r_pend_vld <= 1'b0;
                    end
                end
                S_SODA: begin
                    if (r_cnt == CNT_W'(SODA_CYC - 1)) begin
                        r_cnt   <= '0;
                        r_state <= (r_owed != 3'd0) ? S_EJECT : S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_EJECT: begin
                    if (r_cnt == CNT_W'(EJECT_CYC - 1)) begin
                        r_cnt   <= '0;
                        r_state <= S_WAIT;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_WAIT: begin
                    if (bus.coin_seen_i) begin
                        r_owed  <= r_owed - 3'd1;
                        r_cnt   <= '0;
                        r_state <= (r_owed != 3'd1) ? S_GAP : S_IDLE;
                    end else if (r_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                        r_cnt   <= '0;
                        r_state <= S_FAULT;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_GAP: begin
                    if (r_cnt == CNT_W'(GAP_CYC - 1)) begin
                        r_cnt   <= '0;
                        r_state <= S_EJECT;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_FAULT: r_state <= S_FAULT;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // NOTE: drives decode only flopped state, so async reset drops them with no clock edge.
    assign bus.soda_sol_o   = (r_state == S_SODA);
    assign bus.coin_eject_o = (r_state == S_EJECT);
    assign bus.busy_o       = (r_state != S_IDLE);
    assign bus.fault_o      = (r_state == S_FAULT);
    assign bus.owed_o       = r_owed;
    assign bus.pending_o    = r_pend_vld;
    assign bus.drop_o       = r_drop;

endmodule

// File: tb/tb_vend_dispenser.sv
// Self-checking bench for vend_dispenser: directed scenarios with inline checks
// plus a pulse scoreboard for solenoid drive lengths and owed values.
module tb_vend_dispenser;

    typedef struct {
        bit         is_vend;
        int         len;
        logic [2:0] owed;
    } pulse_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    pulse_t sb_q[$];

    vend_dispenser_if bus ();

    vend_dispenser dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse monitor: measures each solenoid pulse and compares with the queue head.
    int         soda_run;
    int         ej_run;
    logic [2:0] soda_owed;
    logic [2:0] ej_owed;
    initial begin
        soda_run = 0;
        ej_run   = 0;
        soda_owed = '0;
        ej_owed   = '0;
    end

    always @(negedge clk) begin
        pulse_t exp_p;
        if (rst) begin
            soda_run = 0;
            ej_run   = 0;
        end else begin
            if (bus.soda_sol_o) begin
                if (soda_run == 0) soda_owed = bus.owed_o;
                soda_run++;
            end else if (soda_run > 0) begin
                n_checks++;
                if (sb_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL sb_vend_unexpected len=%0d", soda_run);
                end else begin
                    exp_p = sb_q.pop_front();
                    if (!exp_p.is_vend || exp_p.len != soda_run || exp_p.owed !== soda_owed) begin
                        n_errors++;
                        $display("FAIL sb_vend got vend len=%0d owed=%0d exp is_vend=%0d len=%0d owed=%0d",
                                 soda_run, soda_owed, exp_p.is_vend, exp_p.len, exp_p.owed);
                    end
                end
                soda_run = 0;
            end
            if (bus.coin_eject_o) begin
                if (ej_run == 0) ej_owed = bus.owed_o;
                ej_run++;
            end else if (ej_run > 0) begin
                n_checks++;
                if (sb_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL sb_eject_unexpected len=%0d", ej_run);
                end else begin
                    exp_p = sb_q.pop_front();
                    if (exp_p.is_vend || exp_p.len != ej_run || exp_p.owed !== ej_owed) begin
                        n_errors++;
                        $display("FAIL sb_eject got eject len=%0d owed=%0d exp is_vend=%0d len=%0d owed=%0d",
                                 ej_run, ej_owed, exp_p.is_vend, exp_p.len, exp_p.owed);
                    end
                end
                ej_run = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_vend(input logic [2:0] owed);
        sb_q.push_back('{is_vend: 1'b1, len: 8, owed: owed});
    endtask

    task automatic push_eject(input logic [2:0] owed);
        sb_q.push_back('{is_vend: 1'b0, len: 4, owed: owed});
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        bus.soda_i = 1'b0;
        bus.change_i = '0;
        bus.coin_seen_i = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic start_req(input logic [2:0] chg);
        bus.soda_i = 1'b1;
        bus.change_i = chg;
        tick();
        bus.soda_i = 1'b0;
        bus.change_i = '0;
    endtask

    // Checks eight SODA cycles starting at the current one; leaves the sample just after.
    task automatic soda_phase(input logic [2:0] owed);
        for (int i = 1; i <= 8; i++) begin
            n_checks++;
            if (bus.soda_sol_o !== 1'b1 || bus.coin_eject_o !== 1'b0 || bus.owed_o !== owed) begin
                n_errors++;
                $display("FAIL soda_phase cyc=%0d got sol=%b eject=%b owed=%0d exp sol=1 eject=0 owed=%0d",
                         i, bus.soda_sol_o, bus.coin_eject_o, bus.owed_o, owed);
            end
            tick();
        end
    endtask

    // One nickel: four eject cycles, sensor on the third WAIT cycle, then GAP or IDLE.
    task automatic nickel(input logic [2:0] ob);
        logic [2:0] oa;
        oa = ob - 3'd1;
        for (int i = 1; i <= 4; i++) begin
            n_checks++;
            if (bus.coin_eject_o !== 1'b1 || bus.owed_o !== ob) begin
                n_errors++;
                $display("FAIL nickel_eject owed=%0d cyc=%0d got eject=%b owed=%0d exp eject=1",
                         ob, i, bus.coin_eject_o, bus.owed_o);
            end
            tick();
        end
        n_checks++;
        if (bus.coin_eject_o !== 1'b0 || bus.busy_o !== 1'b1) begin
            n_errors++;
            $display("FAIL nickel_wait0 got eject=%b busy=%b exp eject=0 busy=1", bus.coin_eject_o, bus.busy_o);
        end
        tick();
        tick();
        bus.coin_seen_i = 1'b1;
        tick();
        bus.coin_seen_i = 1'b0;
        n_checks++;
        if (bus.owed_o !== oa || bus.busy_o !== (oa != 3'd0) || bus.coin_eject_o !== 1'b0) begin
            n_errors++;
            $display("FAIL nickel_confirm got owed=%0d busy=%b eject=%b exp owed=%0d busy=%b eject=0",
                     bus.owed_o, bus.busy_o, bus.coin_eject_o, oa, (oa != 3'd0));
        end
        if (oa != 3'd0) begin
            tick();
            n_checks++;
            if (bus.coin_eject_o !== 1'b0) begin
                n_errors++;
                $display("FAIL nickel_gap got eject=%b exp 0", bus.coin_eject_o);
            end
            tick();
        end
    endtask

    task automatic sb_drain(input string tag);
        tick();
        tick();
        n_checks++;
        if (sb_q.size() != 0) begin
            n_errors++;
            $display("FAIL sb_drain_%s got %0d pulses outstanding exp 0", tag, sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.soda_i = 1'b0;
        bus.change_i = '0;
        bus.coin_seen_i = 1'b0;
        #2;
        n_checks++;
        if ({bus.soda_sol_o, bus.coin_eject_o, bus.owed_o, bus.busy_o, bus.pending_o, bus.drop_o, bus.fault_o} !== 9'd0) begin
            n_errors++;
            $display("FAIL reset_outputs got sol=%b eject=%b owed=%0d busy=%b pend=%b drop=%b fault=%b exp all 0",
                     bus.soda_sol_o, bus.coin_eject_o, bus.owed_o, bus.busy_o, bus.pending_o, bus.drop_o, bus.fault_o);
        end
        tick();
        rst = 1'b0;
        tick();
        n_checks++;
        if (bus.busy_o !== 1'b0 || bus.fault_o !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_release got busy=%b fault=%b exp 0 0", bus.busy_o, bus.fault_o);
        end
    endtask

    task automatic test_vend_no_change();
        push_vend(3'd0);
        start_req(3'd0);
        soda_phase(3'd0);
        n_checks++;
        if (bus.busy_o !== 1'b0 || bus.soda_sol_o !== 1'b0 || bus.coin_eject_o !== 1'b0) begin
            n_errors++;
            $display("FAIL vend0_done got busy=%b sol=%b eject=%b exp 0 0 0", bus.busy_o, bus.soda_sol_o, bus.coin_eject_o);
        end
        sb_drain("vend0");
    endtask

    task automatic test_change3();
        push_vend(3'd3);
        push_eject(3'd3);
        push_eject(3'd2);
        push_eject(3'd1);
        start_req(3'd3);
        soda_phase(3'd3);
        nickel(3'd3);
        nickel(3'd2);
        nickel(3'd1);
        sb_drain("change3");
    endtask

    task automatic test_timeout_fault();
        push_vend(3'd2);
        push_eject(3'd2);
        start_req(3'd2);
        soda_phase(3'd2);
        repeat (4) tick();
        repeat (15) tick();
        n_checks++;
        if (bus.fault_o !== 1'b0 || bus.busy_o !== 1'b1) begin
            n_errors++;
            $display("FAIL timeout_last_wait got fault=%b busy=%b exp 0 1", bus.fault_o, bus.busy_o);
        end
        tick();
        n_checks++;
        if (bus.fault_o !== 1'b1 || bus.coin_eject_o !== 1'b0 || bus.busy_o !== 1'b1 || bus.soda_sol_o !== 1'b0) begin
            n_errors++;
            $display("FAIL timeout_fault got fault=%b eject=%b busy=%b sol=%b exp 1 0 1 0",
                     bus.fault_o, bus.coin_eject_o, bus.busy_o, bus.soda_sol_o);
        end
        bus.coin_seen_i = 1'b1;
        tick();
        bus.coin_seen_i = 1'b0;
        n_checks++;
        if (bus.owed_o !== 3'd2) begin
            n_errors++;
            $display("FAIL fault_coin_ignored got owed=%0d exp 2", bus.owed_o);
        end
        start_req(3'd1);
        n_checks++;
        if (bus.pending_o !== 1'b1 || bus.drop_o !== 1'b0) begin
            n_errors++;
            $display("FAIL fault_fill_slot got pend=%b drop=%b exp 1 0", bus.pending_o, bus.drop_o);
        end
        start_req(3'd3);
        n_checks++;
        if (bus.drop_o !== 1'b1 || bus.fault_o !== 1'b1) begin
            n_errors++;
            $display("FAIL fault_drop got drop=%b fault=%b exp 1 1", bus.drop_o, bus.fault_o);
        end
        tick();
        n_checks++;
        if (bus.drop_o !== 1'b0) begin
            n_errors++;
            $display("FAIL fault_drop_width got drop=%b exp 0", bus.drop_o);
        end
        sb_drain("timeout");
        rst = 1'b1;
        #1;
        n_checks++;
        if ({bus.fault_o, bus.busy_o, bus.pending_o, bus.owed_o} !== 6'd0) begin
            n_errors++;
            $display("FAIL fault_reset got fault=%b busy=%b pend=%b owed=%0d exp all 0",
                     bus.fault_o, bus.busy_o, bus.pending_o, bus.owed_o);
        end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        push_vend(3'd1);
        push_eject(3'd1);
        push_vend(3'd4);
        push_eject(3'd4);
        push_eject(3'd3);
        push_eject(3'd2);
        push_eject(3'd1);
        start_req(3'd1);
        tick();
        start_req(3'd4);
        n_checks++;
        if (bus.pending_o !== 1'b1 || bus.drop_o !== 1'b0) begin
            n_errors++;
            $display("FAIL b2b_pend_b got pend=%b drop=%b exp 1 0", bus.pending_o, bus.drop_o);
        end
        start_req(3'd2);
        n_checks++;
        if (bus.drop_o !== 1'b1 || bus.pending_o !== 1'b1) begin
            n_errors++;
            $display("FAIL b2b_drop_c got drop=%b pend=%b exp 1 1", bus.drop_o, bus.pending_o);
        end
        tick();
        n_checks++;
        if (bus.drop_o !== 1'b0) begin
            n_errors++;
            $display("FAIL b2b_drop_once got drop=%b exp 0", bus.drop_o);
        end
        repeat (4) tick();
        nickel(3'd1);
        n_checks++;
        if (bus.pending_o !== 1'b1 || bus.busy_o !== 1'b0) begin
            n_errors++;
            $display("FAIL b2b_a_done got pend=%b busy=%b exp 1 0", bus.pending_o, bus.busy_o);
        end
        tick();
        n_checks++;
        if (bus.pending_o !== 1'b0 || bus.owed_o !== 3'd4) begin
            n_errors++;
            $display("FAIL b2b_b_start got pend=%b owed=%0d exp 0 4", bus.pending_o, bus.owed_o);
        end
        soda_phase(3'd4);
        nickel(3'd4);
        nickel(3'd3);
        nickel(3'd2);
        nickel(3'd1);
        sb_drain("b2b");
    endtask

    task automatic test_illegal_change();
        start_req(3'd6);
        n_checks++;
        if (bus.fault_o !== 1'b1 || bus.soda_sol_o !== 1'b0 || bus.busy_o !== 1'b1) begin
            n_errors++;
            $display("FAIL illegal_fault got fault=%b sol=%b busy=%b exp 1 0 1", bus.fault_o, bus.soda_sol_o, bus.busy_o);
        end
        sb_drain("illegal");
        apply_reset();
    endtask

    task automatic test_reset_mid_eject();
        push_vend(3'd2);
        start_req(3'd2);
        bus.soda_i = 1'b1;
        bus.change_i = 3'd0;
        tick();
        bus.soda_i = 1'b0;
        repeat (7) tick();
        tick();
        n_checks++;
        if (bus.coin_eject_o !== 1'b1 || bus.pending_o !== 1'b1) begin
            n_errors++;
            $display("FAIL mid_eject_setup got eject=%b pend=%b exp 1 1", bus.coin_eject_o, bus.pending_o);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({bus.coin_eject_o, bus.busy_o, bus.owed_o, bus.pending_o} !== 6'd0) begin
            n_errors++;
            $display("FAIL mid_eject_async got eject=%b busy=%b owed=%0d pend=%b exp all 0",
                     bus.coin_eject_o, bus.busy_o, bus.owed_o, bus.pending_o);
        end
        tick();
        rst = 1'b0;
        tick();
        push_vend(3'd0);
        start_req(3'd0);
        soda_phase(3'd0);
        n_checks++;
        if (bus.busy_o !== 1'b0) begin
            n_errors++;
            $display("FAIL post_reset_vend got busy=%b exp 0", bus.busy_o);
        end
        sb_drain("reset_mid");
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        test_reset();
        test_vend_no_change();
        test_change3();
        test_timeout_fault();
        test_back_to_back();
        test_illegal_change();
        test_reset_mid_eject();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
